// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers used by the timing generator and its delay line.
package vga_pkg;

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned FRAME_W = 8;

    localparam int unsigned H_VISIBLE_DEF = 640;
    localparam int unsigned H_FRONT_DEF   = 16;
    localparam int unsigned H_SYNC_DEF    = 96;
    localparam int unsigned H_BACK_DEF    = 48;
    localparam int unsigned V_VISIBLE_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;
    localparam int unsigned SYNC_DLY_DEF  = 1;

    // First and last counter value of the sync pulse within a line or frame.
    function automatic int unsigned sync_start(int unsigned visible, int unsigned front);
        return visible + front;
    endfunction

    function automatic int unsigned sync_end(int unsigned visible, int unsigned front,
                                             int unsigned sync);
        return visible + front + sync - 1;
    endfunction

    function automatic int unsigned timing_total(int unsigned visible, int unsigned front,
                                                 int unsigned sync, int unsigned back);
        return visible + front + sync + back;
    endfunction

    localparam int unsigned H_TOTAL_DEF =
        timing_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
    localparam int unsigned V_TOTAL_DEF =
        timing_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
    localparam int unsigned H_SYNC_START_DEF = sync_start(H_VISIBLE_DEF, H_FRONT_DEF);
    localparam int unsigned H_SYNC_END_DEF   = sync_end(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF);
    localparam int unsigned V_SYNC_START_DEF = sync_start(V_VISIBLE_DEF, V_FRONT_DEF);
    localparam int unsigned V_SYNC_END_DEF   = sync_end(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF);

    // Active-low sync pair carried through the delay line.
    typedef struct packed {
        logic hs;
        logic vs;
    } sync_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Bundle of the timing generator outputs for consumers (pixel pipeline, sprite engine).
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic [CNT_W-1:0]   DrawX;
    logic [CNT_W-1:0]   DrawY;
    logic               blank;
    logic               hs;
    logic               vs;
    logic               frame_start;
    logic [FRAME_W-1:0] frame_cnt;

    modport master (output DrawX, DrawY, blank, hs, vs, frame_start, frame_cnt);
    modport slave  (input  DrawX, DrawY, blank, hs, vs, frame_start, frame_cnt);

endinterface

// File: rtl/vga_sync_delay.sv
// Delays the registered hs/vs pair by DEPTH pixel clocks; resets to inactive (all 1s).
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int unsigned DEPTH = SYNC_DLY_DEF
) (
    input  logic  vga_clk,
    input  logic  reset_n,
    input  sync_t sync_in,
    output sync_t sync_out
);

    if (DEPTH == 0) begin : g_pass
        assign sync_out = sync_in;
    end else begin : g_shift
        sync_t [DEPTH-1:0] stage;

        always_ff @(posedge vga_clk or negedge reset_n) begin
            if (!reset_n) begin
                stage <= '1;
            end else begin
                stage[0] <= sync_in;
                for (int i = 1; i < int'(DEPTH); i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign sync_out = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster counters with blank, delayed active-low syncs and a frame counter.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter int unsigned SYNC_DLY  = SYNC_DLY_DEF
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    output logic [CNT_W-1:0]   DrawX,
    output logic [CNT_W-1:0]   DrawY,
    output logic               blank,
    output logic               hs,
    output logic               vs,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = timing_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = timing_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(sync_start(H_VISIBLE, H_FRONT));
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(sync_end(H_VISIBLE, H_FRONT, H_SYNC));
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(sync_start(V_VISIBLE, V_FRONT));
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(sync_end(V_VISIBLE, V_FRONT, V_SYNC));

    logic [CNT_W-1:0] x_nxt_c;
    logic [CNT_W-1:0] y_nxt_c;
    logic             blank_nxt_c;
    logic             frame_hit_c;
    sync_t            raw_nxt_c;
    sync_t            raw_sync;
    sync_t            sync_dly;

    // Next-state raster position; every registered output is derived from it so all align.
    always_comb begin
        x_nxt_c     = DrawX + CNT_W'(1);
        y_nxt_c     = DrawY;
        if (DrawX == H_LAST) begin
            x_nxt_c = '0;
            y_nxt_c = (DrawY == V_LAST) ? '0 : DrawY + CNT_W'(1);
        end
        blank_nxt_c  = (x_nxt_c < H_VIS_END) && (y_nxt_c < V_VIS_END);
        frame_hit_c  = (x_nxt_c == '0) && (y_nxt_c == '0);
        raw_nxt_c.hs = !((x_nxt_c >= HS_START) && (x_nxt_c <= HS_END));
        raw_nxt_c.vs = !((y_nxt_c >= VS_START) && (y_nxt_c <= VS_END));
    end

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            raw_sync    <= '1;
        end else begin
            DrawX       <= x_nxt_c;
            DrawY       <= y_nxt_c;
            blank       <= blank_nxt_c;
            frame_start <= frame_hit_c;
            raw_sync    <= raw_nxt_c;
            if (frame_hit_c) begin
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    // Extra sync latency to line hs/vs up with a pipelined pixel path.
    vga_sync_delay #(
        .DEPTH (SYNC_DLY)
    ) u_sync_delay (
        .vga_clk  (vga_clk),
        .reset_n  (reset_n),
        .sync_in  (raw_sync),
        .sync_out (sync_dly)
    );

    assign hs = sync_dly.hs;
    assign vs = sync_dly.vs;

endmodule
